// File: rtl/audio_pkg.sv
// Constants and types shared by the sound player and the capture recorder.
// Declarations only; no latency.
// No flow control.
package audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int BOINK_LEN    = 15435;
    localparam int SAMPLE_SHIFT = 14;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RECORD,
        DONE
    } rec_state_t;

    // Magnitude of a signed sample. The most negative value has no positive
    // twin, so it clamps to the largest positive value.
    function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] r;
        if (s == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
            r = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (s < 0) begin
            r = $unsigned(-s);
        end else begin
            r = $unsigned(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_capture_recorder_if.sv
// Capture-side bus: controller input FIFO head/pop plus sample RAM write port.
// Signal bundle only; no latency.
// FIFO pop mirrors availability, so there is no backpressure toward the controller.
interface audio_capture_recorder_if #(
    parameter int ADDR_W = 23
);
    logic                             audio_in_available;
    logic [31:0]                      left_channel_audio_in;
    logic                             read_audio_in;
    logic [ADDR_W-1:0]                mem_address;
    logic [audio_pkg::SAMPLE_W-1:0]   mem_data;
    logic                             mem_wren;

    // Recorder side: consumes the FIFO, drives the RAM write port.
    modport master (
        input  audio_in_available,
        input  left_channel_audio_in,
        output read_audio_in,
        output mem_address,
        output mem_data,
        output mem_wren
    );

    // Controller/RAM side.
    modport slave (
        output audio_in_available,
        output left_channel_audio_in,
        input  read_audio_in,
        input  mem_address,
        input  mem_data,
        input  mem_wren
    );
endinterface

// File: rtl/peak_tracker.sv
// Holds the largest saturated sample magnitude seen since the last clear.
// Updates one cycle after en; clear has priority over update.
// No flow control; samples are taken whenever en is high.
module peak_tracker import audio_pkg::*; (
    input  logic                       CLOCK_50,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0]        peak
);

    logic [SAMPLE_W-1:0] mag;

    assign mag = abs_sat(sample);

    // A new recording starts from zero even if a sample lands on the same cycle.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (clr) begin
            peak <= '0;
        end else if (en && (mag > peak)) begin
            peak <= mag;
        end
    end

endmodule

// File: rtl/audio_capture_recorder.sv
// Records decimated left-channel samples from the audio input FIFO into sample RAM.
// RAM write is registered one cycle after the FIFO accept that produced it.
// Never backpressures: the FIFO is popped whenever it is non-empty, in every state.
module audio_capture_recorder import audio_pkg::*; #(
    parameter int MAX_ADDR = BOINK_LEN,
    parameter int ADDR_W   = 23,
    parameter int DECIM    = 1,
    parameter int SHIFT    = SAMPLE_SHIFT
) (
    input  logic                      CLOCK_50,
    input  logic                      KEY,
    input  logic                      start,
    input  logic                      abort,
    audio_capture_recorder_if.master  aif,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         sample_count,
    output logic [SAMPLE_W-1:0]       peak
);

    localparam int                DW        = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DW-1:0]     DEC_LAST  = DW'(DECIM - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);

    rec_state_t                 state;
    logic [DW-1:0]              dec_cnt;
    logic                       accept;
    logic                       rearm;
    logic                       keep;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       unused_bits;

    assign aif.read_audio_in = aif.audio_in_available;
    assign accept            = aif.audio_in_available;
    assign sample            = aif.left_channel_audio_in[SHIFT +: SAMPLE_W];
    assign unused_bits       = ^aif.left_channel_audio_in;

    // Start only takes effect when not already recording.
    assign rearm = start && ((state == IDLE) || (state == DONE));
    // A sample is kept on the last accept of each decimation group, unless aborted.
    assign keep  = (state == RECORD) && !abort && accept && (dec_cnt == DEC_LAST);
    assign busy  = (state == ARM) || (state == RECORD);

    // Recording sequencer: flush one stale sample, then decimate and write until full or aborted.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            state            <= IDLE;
            dec_cnt          <= '0;
            aif.mem_address  <= '0;
            aif.mem_data     <= '0;
            aif.mem_wren     <= 1'b0;
            done             <= 1'b0;
            sample_count     <= '0;
        end else begin
            aif.mem_wren <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= ARM;
                        dec_cnt      <= '0;
                        done         <= 1'b0;
                        sample_count <= '0;
                    end
                end
                ARM: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (accept) begin
                        state <= RECORD;
                    end
                end
                RECORD: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (accept) begin
                        if (dec_cnt == DEC_LAST) begin
                            dec_cnt         <= '0;
                            aif.mem_wren    <= 1'b1;
                            aif.mem_address <= sample_count;
                            aif.mem_data    <= sample;
                            sample_count    <= sample_count + ADDR_W'(1);
                            if (sample_count == LAST_ADDR) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            dec_cnt <= dec_cnt + DW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    peak_tracker u_peak (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (KEY),
        .clr      (rearm),
        .en       (keep),
        .sample   (sample),
        .peak     (peak)
    );

endmodule

// File: tb/tb_audio_capture_recorder.sv
// Bench for audio_capture_recorder: two instances (short recording, DECIM=1 and DECIM=3)
// share one stimulus stream; directed scenarios plus a randomized run against a reference model.
module tb_audio_capture_recorder;

    localparam int A_MAX = 7;
    localparam int A_DEC = 1;
    localparam int B_MAX = 31;
    localparam int B_DEC = 3;

    logic        CLOCK_50;
    logic        KEY;
    logic        start;
    logic        abort;
    logic        avail;
    logic [31:0] din;

    logic        a_busy, a_done, b_busy, b_done;
    logic [22:0] a_cnt, b_cnt;
    logic [15:0] a_peak, b_peak;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, index 0 = instance A, 1 = instance B
    bit          m_busy [2];
    bit          m_flushed [2];
    bit          m_done [2];
    bit          m_wren [2];
    int          m_acc [2];
    int          m_cnt [2];
    int          m_peak [2];
    int          m_addr [2];
    logic [15:0] m_data [2];

    audio_capture_recorder_if #(.ADDR_W(23)) ia ();
    audio_capture_recorder_if #(.ADDR_W(23)) ib ();

    assign ia.audio_in_available    = avail;
    assign ia.left_channel_audio_in = din;
    assign ib.audio_in_available    = avail;
    assign ib.left_channel_audio_in = din;

    audio_capture_recorder #(.MAX_ADDR(A_MAX), .ADDR_W(23), .DECIM(A_DEC), .SHIFT(14)) u_a (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .start(start), .abort(abort), .aif(ia),
        .busy(a_busy), .done(a_done), .sample_count(a_cnt), .peak(a_peak));

    audio_capture_recorder #(.MAX_ADDR(B_MAX), .ADDR_W(23), .DECIM(B_DEC), .SHIFT(14)) u_b (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .start(start), .abort(abort), .aif(ib),
        .busy(b_busy), .done(b_done), .sample_count(b_cnt), .peak(b_peak));

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish, got=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word(input int s);
        logic [15:0] v;
        v = 16'(s);
        return {2'b00, v, 14'b0};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_flushed[i] = 0; m_done[i] = 0; m_wren[i] = 0;
            m_acc[i] = 0; m_cnt[i] = 0; m_peak[i] = 0; m_addr[i] = 0; m_data[i] = '0;
        end
    endfunction

    // Recording rules: after start the first accepted sample is thrown away, then every
    // DECIM-th accepted sample is written to the next address until MAX+1 words or abort.
    function automatic void model_step(input int i, input bit av, input logic [31:0] d,
                                       input bit st, input bit ab);
        int sv, mag, dec, mx;
        dec = (i == 0) ? A_DEC : B_DEC;
        mx  = (i == 0) ? A_MAX : B_MAX;
        sv  = int'($signed(d[29:14]));
        mag = (sv < 0) ? -sv : sv;
        if (mag > 32767) mag = 32767;
        m_wren[i] = 0;
        if (!m_busy[i]) begin
            if (st) begin
                m_busy[i] = 1; m_flushed[i] = 0; m_acc[i] = 0;
                m_cnt[i] = 0; m_peak[i] = 0; m_done[i] = 0;
            end
        end else if (ab) begin
            m_busy[i] = 0; m_done[i] = 1;
        end else if (av) begin
            if (!m_flushed[i]) begin
                m_flushed[i] = 1;
            end else begin
                m_acc[i]++;
                if (m_acc[i] % dec == 0) begin
                    m_wren[i] = 1; m_addr[i] = m_cnt[i]; m_data[i] = d[29:14];
                    m_cnt[i]++;
                    if (mag > m_peak[i]) m_peak[i] = mag;
                    if (m_cnt[i] == mx + 1) begin
                        m_busy[i] = 0; m_done[i] = 1;
                    end
                end
            end
        end
    endfunction

    // Apply one cycle of stimulus and return 1ns after the sampling edge.
    task automatic drive(input bit av, input logic [31:0] d, input bit st, input bit ab);
        avail = av; din = d; start = st; abort = ab;
        for (int i = 0; i < 2; i++) model_step(i, av, d, st, ab);
        @(posedge CLOCK_50); #1;
    endtask

    task automatic do_reset();
        KEY = 1'b0; avail = 1'b0; din = '0; start = 1'b0; abort = 1'b0;
        model_reset();
        #5 KEY = 1'b1;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_reset();
        KEY = 1'b0; avail = 1'b0; din = '0; start = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK_50);
        #1 KEY = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        n_vec++; if ({ia.mem_wren, ia.mem_address, ia.mem_data, a_done, a_busy, a_cnt, a_peak, ia.read_audio_in} !== '0) begin
            n_err++; $display("FAIL reset_a outputs got=%h required=0", {ia.mem_wren, ia.mem_address, ia.mem_data, a_done, a_busy, a_cnt, a_peak, ia.read_audio_in}); end
        n_vec++; if ({ib.mem_wren, ib.mem_address, ib.mem_data, b_done, b_busy, b_cnt, b_peak, ib.read_audio_in} !== '0) begin
            n_err++; $display("FAIL reset_b outputs got=%h required=0", {ib.mem_wren, ib.mem_address, ib.mem_data, b_done, b_busy, b_cnt, b_peak, ib.read_audio_in}); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(0, '0, 1, 0);
        n_vec++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b required=1", a_busy); end
        drive(1, 32'h0000_4000, 0, 0);
        n_vec++; if (ia.read_audio_in !== 1'b1) begin n_err++; $display("FAIL basic_read got=%b required=1", ia.read_audio_in); end
        n_vec++; if (ia.mem_wren !== 1'b0) begin n_err++; $display("FAIL basic_flush_wren got=%b required=0", ia.mem_wren); end
        drive(1, 32'h0000_8000, 0, 0);
        n_vec++; if ({ia.mem_wren, ia.mem_address, ia.mem_data} !== {1'b1, 23'd0, 16'h0002}) begin
            n_err++; $display("FAIL basic_wr0 got=%b/%0d/%h required=1/0/0002", ia.mem_wren, ia.mem_address, ia.mem_data); end
        drive(1, 32'h0000_C000, 0, 0);
        n_vec++; if ({ia.mem_wren, ia.mem_address, ia.mem_data} !== {1'b1, 23'd1, 16'h0003}) begin
            n_err++; $display("FAIL basic_wr1 got=%b/%0d/%h required=1/1/0003", ia.mem_wren, ia.mem_address, ia.mem_data); end
        drive(0, '0, 0, 0);
        n_vec++; if ({ia.mem_wren, ia.mem_address, ia.mem_data, a_cnt} !== {1'b0, 23'd1, 16'h0003, 23'd2}) begin
            n_err++; $display("FAIL basic_hold got=%b/%0d/%h cnt=%0d required=0/1/0003 cnt=2", ia.mem_wren, ia.mem_address, ia.mem_data, a_cnt); end
    endtask

    task automatic test_peak();
        int samp [3];
        int expk [3];
        samp = '{-100, 300, -32768};
        expk = '{100, 300, 32767};
        do_reset();
        drive(0, '0, 1, 0);
        drive(1, word(5), 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, word(samp[k]), 0, 0);
            n_vec++; if (a_peak !== 16'(expk[k])) begin n_err++; $display("FAIL peak_%0d got=%0d required=%0d", k, a_peak, expk[k]); end
            n_vec++; if (ia.mem_data !== 16'(samp[k])) begin n_err++; $display("FAIL peak_data_%0d got=%h required=%h", k, ia.mem_data, 16'(samp[k])); end
        end
    endtask

    task automatic test_max_addr();
        logic [31:0] w;
        do_reset();
        drive(0, '0, 1, 0);
        drive(1, $urandom, 0, 0);
        for (int c = 0; c <= A_MAX; c++) begin
            w = $urandom;
            drive(1, w, 0, 0);
            n_vec++; if ({ia.mem_wren, ia.mem_address, ia.mem_data} !== {1'b1, 23'(c), w[29:14]}) begin
                n_err++; $display("FAIL max_wr%0d got=%b/%0d/%h required=1/%0d/%h", c, ia.mem_wren, ia.mem_address, ia.mem_data, c, w[29:14]); end
        end
        drive(1, $urandom, 0, 0);
        n_vec++; if ({a_done, a_busy, ia.mem_wren} !== 3'b100) begin
            n_err++; $display("FAIL max_done done/busy/wren got=%b required=100", {a_done, a_busy, ia.mem_wren}); end
        for (int c = 0; c < 4; c++) begin
            drive(1, $urandom, 0, 0);
            n_vec++; if ({ia.mem_wren, a_cnt} !== {1'b0, 23'd8}) begin
                n_err++; $display("FAIL max_nowrap_%0d wren=%b cnt=%0d required wren=0 cnt=8", c, ia.mem_wren, a_cnt); end
        end
    endtask

    task automatic test_decim();
        int k, nw;
        bit exp_w;
        do_reset();
        drive(0, '0, 1, 0);
        drive(1, word(777), 0, 0);
        k = 1; nw = 0;
        while (k <= 9) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(0, '0, 0, 0);
                n_vec++; if (ib.mem_wren !== 1'b0) begin n_err++; $display("FAIL decim_gap got=%b required=0", ib.mem_wren); end
            end else begin
                drive(1, word(k * 11), 0, 0);
                exp_w = (k % 3 == 0);
                n_vec++; if (ib.mem_wren !== exp_w) begin n_err++; $display("FAIL decim_wren_k%0d got=%b required=%b", k, ib.mem_wren, exp_w); end
                if (exp_w) begin
                    n_vec++; if ({ib.mem_address, ib.mem_data} !== {23'(nw), 16'(k * 11)}) begin
                        n_err++; $display("FAIL decim_wr_k%0d got=%0d/%h required=%0d/%h", k, ib.mem_address, ib.mem_data, nw, 16'(k * 11)); end
                    nw++;
                end
                k++;
            end
        end
        drive(0, '0, 0, 0);
        n_vec++; if ({b_cnt, b_busy} !== {23'd3, 1'b1}) begin n_err++; $display("FAIL decim_cnt got=%0d busy=%b required=3 busy=1", b_cnt, b_busy); end
    endtask

    task automatic test_abort();
        do_reset();
        drive(0, '0, 1, 0);
        drive(1, word(1), 0, 0);
        for (int k = 0; k < 4; k++) drive(1, word(k + 10), 0, 0);
        n_vec++; if ({ia.mem_wren, ia.mem_address} !== {1'b1, 23'd3}) begin
            n_err++; $display("FAIL abort_pre got=%b/%0d required=1/3", ia.mem_wren, ia.mem_address); end
        drive(1, word(50), 1, 1);
        n_vec++; if ({ia.mem_wren, a_done, a_busy, a_cnt} !== {1'b0, 1'b1, 1'b0, 23'd4}) begin
            n_err++; $display("FAIL abort_state wren/done/busy=%b cnt=%0d required 010 cnt=4", {ia.mem_wren, a_done, a_busy}, a_cnt); end
        drive(1, word(51), 0, 0);
        drive(1, word(52), 0, 0);
        n_vec++; if ({ia.mem_wren, a_done, a_cnt} !== {1'b0, 1'b1, 23'd4}) begin
            n_err++; $display("FAIL abort_hold wren/done=%b cnt=%0d required 01 cnt=4", {ia.mem_wren, a_done}, a_cnt); end
        drive(0, '0, 1, 0);
        n_vec++; if ({a_busy, a_done, a_cnt, a_peak} !== {1'b1, 1'b0, 23'd0, 16'd0}) begin
            n_err++; $display("FAIL rearm busy/done=%b cnt=%0d peak=%0d required 10 0 0", {a_busy, a_done}, a_cnt, a_peak); end
        drive(1, word(2), 0, 0);
        drive(1, word(20), 0, 0);
        drive(1, word(21), 0, 0);
        n_vec++; if (ia.mem_wren !== 1'b1) begin n_err++; $display("FAIL midrec_wren got=%b required=1", ia.mem_wren); end
        avail = 1'b0; start = 1'b0; abort = 1'b0;
        #3 KEY = 1'b0;
        model_reset();
        #1;
        n_vec++; if ({ia.mem_wren, a_done, a_busy, a_cnt} !== {1'b0, 1'b0, 1'b0, 23'd0}) begin
            n_err++; $display("FAIL async_reset wren/done/busy=%b cnt=%0d required 000 0", {ia.mem_wren, a_done, a_busy}, a_cnt); end
        #2 KEY = 1'b1;
        @(posedge CLOCK_50); #1;
    endtask

    task automatic test_random();
        bit av, st, ab;
        logic        wr [2];
        logic        dn [2];
        logic        bz [2];
        logic        rd [2];
        logic [22:0] ad [2];
        logic [22:0] ct [2];
        logic [15:0] dt [2];
        logic [15:0] pk [2];
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            av = ($urandom_range(0, 9) < 7);
            st = ($urandom_range(0, 39) == 0);
            ab = ($urandom_range(0, 99) == 0);
            drive(av, $urandom, st, ab);
            wr[0] = ia.mem_wren;      wr[1] = ib.mem_wren;
            ad[0] = ia.mem_address;   ad[1] = ib.mem_address;
            dt[0] = ia.mem_data;      dt[1] = ib.mem_data;
            rd[0] = ia.read_audio_in; rd[1] = ib.read_audio_in;
            dn[0] = a_done; dn[1] = b_done;
            bz[0] = a_busy; bz[1] = b_busy;
            ct[0] = a_cnt;  ct[1] = b_cnt;
            pk[0] = a_peak; pk[1] = b_peak;
            for (int i = 0; i < 2; i++) begin
                n_vec++; if (rd[i] !== av) begin n_err++; $display("FAIL rand_read dut%0d cyc%0d got=%b required=%b", i, c, rd[i], av); end
                n_vec++; if (wr[i] !== m_wren[i]) begin n_err++; $display("FAIL rand_wren dut%0d cyc%0d got=%b required=%b", i, c, wr[i], m_wren[i]); end
                n_vec++; if ({ad[i], dt[i]} !== {23'(m_addr[i]), m_data[i]}) begin
                    n_err++; $display("FAIL rand_addr_data dut%0d cyc%0d got=%0d/%h required=%0d/%h", i, c, ad[i], dt[i], m_addr[i], m_data[i]); end
                n_vec++; if ({dn[i], bz[i]} !== {m_done[i], m_busy[i]}) begin
                    n_err++; $display("FAIL rand_status dut%0d cyc%0d done/busy got=%b%b required=%b%b", i, c, dn[i], bz[i], m_done[i], m_busy[i]); end
                n_vec++; if ({ct[i], pk[i]} !== {23'(m_cnt[i]), 16'(m_peak[i])}) begin
                    n_err++; $display("FAIL rand_cnt_peak dut%0d cyc%0d got=%0d/%0d required=%0d/%0d", i, c, ct[i], pk[i], m_cnt[i], m_peak[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_peak();
        test_max_addr();
        test_decim();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
